// File: rtl/memristor_mult_pkg.sv
// rtl/memristor_mult_pkg.sv - shared encodings and defaults for the memristor multiplier scheduler
//   ST_*            2-bit scheduler FSM state encodings
//   *_DEF           default NREQ / DW / PW / TIMEOUT
//   RSP_ERR_*       meaning of the rsp_err response flag
package memristor_mult_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int DW_DEF      = 4;
  localparam int PW_DEF      = 8;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  // rsp_err = 1 means the core never signalled done; the product is forced to 0
  localparam logic RSP_ERR_OK      = 1'b0;
  localparam logic RSP_ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/memristor_rr_arbiter.sv
// rtl/memristor_rr_arbiter.sv - combinational round-robin arbiter
//   req_i  in   N    request vector
//   ptr_i  in   IW   index of the last winner; search starts at ptr_i+1
//   gnt_o  out  N    one-hot grant (0 when no request)
//   idx_o  out  IW   index of the granted requester
//   any_o  out  1    at least one request present
module memristor_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  // Walk ptr+1 .. ptr+N modulo N; the first set request wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/memristor_mult_rr_scheduler.sv
// rtl/memristor_mult_rr_scheduler.sv - round-robin scheduler sharing one signed multiplier core
//   ACLK/ARESETn                 clock, async active-low reset
//   req_valid/req_a/req_b        per-requester operand request channel (packed by DW)
//   req_ready                    one-hot accept, IDLE only
//   rsp_valid/rsp_product/rsp_err/rsp_ready   per-requester response channel
//   core_start/core_a/core_b     start pulse and held operands to the core
//   core_done/core_product       core completion and result
//   busy/grant_id                status: FSM not idle, requester being served
module memristor_mult_rr_scheduler
  import memristor_mult_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int DW      = DW_DEF,
  parameter int PW      = PW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [PW-1:0]      rsp_product,
  output logic               rsp_err,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic               core_start,
  output logic [DW-1:0]      core_a,
  output logic [DW-1:0]      core_b,
  input  logic               core_done,
  input  logic [PW-1:0]      core_product,
  output logic               busy,
  output logic [GW-1:0]      grant_id
);

  localparam int WW = $clog2(TIMEOUT + 1);

  sched_state_e  state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [DW-1:0] core_a_q, core_a_d;
  logic [DW-1:0] core_b_q, core_b_d;
  logic [PW-1:0] product_q, product_d;
  logic          err_q, err_d;
  logic [WW-1:0] wdog_q, wdog_d;

  logic [NREQ-1:0] arb_gnt;
  logic [GW-1:0]   arb_idx;
  logic            arb_any;

  memristor_rr_arbiter #(
    .N  (NREQ),
    .IW (GW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= GW'(NREQ - 1);
      grant_id_q <= '0;
      core_a_q   <= '0;
      core_b_q   <= '0;
      product_q  <= '0;
      err_q      <= RSP_ERR_OK;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      core_a_q   <= core_a_d;
      core_b_q   <= core_b_d;
      product_q  <= product_d;
      err_q      <= err_d;
      wdog_q     <= wdog_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    core_a_d   = core_a_q;
    core_b_d   = core_b_q;
    product_d  = product_q;
    err_d      = err_q;
    wdog_d     = wdog_q;
    req_ready  = '0;
    rsp_valid  = '0;
    core_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The grant is always a valid requester, so offering ready is the handshake.
        // Ready is held low while reset is asserted so every output reads 0 in reset.
        if (arb_any && ARESETn) begin
          req_ready  = arb_gnt;
          grant_id_d = arb_idx;
          rr_ptr_d   = arb_idx;
          for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
              core_a_d = req_a[i*DW +: DW];
              core_b_d = req_b[i*DW +: DW];
            end
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        core_start = 1'b1;
        wdog_d     = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // done is checked first so it wins over a timeout in the same cycle
        if (core_done) begin
          product_d = core_product;
          err_d     = RSP_ERR_OK;
          state_d   = ST_RESP;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          product_d = '0;
          err_d     = RSP_ERR_TIMEOUT;
          state_d   = ST_RESP;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      ST_RESP: begin
        rsp_valid[grant_id_q] = 1'b1;
        if (rsp_ready[grant_id_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign core_a      = core_a_q;
  assign core_b      = core_b_q;
  assign rsp_product = product_q;
  assign rsp_err     = err_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
